// File: rtl/stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// stream_demux_1xn
//
// Registered 1-to-N demultiplexer for valid/ready streams. Each output channel
// owns a one-entry holding register, so a stalled consumer only blocks words
// addressed to its own channel. Words whose sel points past the last channel
// are accepted and thrown away, and a saturating counter records how many.
//
// Parameters:
//   WIDTH  data word width in bits (>=1)
//   N      number of output channels (2..16)
//   SEL_W  select width, N <= 2**SEL_W
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer offers in_data/sel
//   in_ready   block accepts this cycle (combinational, 0 during rst)
//   in_data    input word
//   sel        destination channel index
//   bcast      (only with DEMUX_BCAST_EN) load the word into every channel
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word
//   out_data   channel k word at [k*WIDTH +: WIDTH]
//   drop_cnt   words dropped for out-of-range sel, saturates at 255
//
// Build option:
//   DEMUX_BCAST_EN  when defined, adds the bcast input and broadcast loading.
// ---------------------------------------------------------------------------
module stream_demux_1xn #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     sel,
`ifdef DEMUX_BCAST_EN
    input  logic                 bcast,
`endif
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [7:0]           drop_cnt
);

    // Reject configurations where sel cannot address every channel.
    if (N > 2**SEL_W) begin : g_sel_check
        $error("stream_demux_1xn: N=%0d does not fit in SEL_W=%0d bits", N, SEL_W);
    end
    if (N < 2 || N > 16) begin : g_n_check
        $error("stream_demux_1xn: N=%0d outside supported range 2..16", N);
    end

    logic [N-1:0] slot_free;
    logic [N-1:0] sel_hit;
    logic         sel_free;
    logic         sel_in_range;
    logic         bcast_on;
    logic         accept;
    logic [N-1:0] load;
    logic         drop;

`ifdef DEMUX_BCAST_EN
    assign bcast_on = bcast;
`else
    assign bcast_on = 1'b0;
`endif

    // A slot can take a new word if it is empty or is being emptied this cycle.
    assign slot_free = ~out_valid | out_ready;

    // Decode sel into a one-hot channel hit. Comparing against each channel
    // index (rather than indexing slot_free with sel) keeps out-of-range
    // selects from ever reading past the end of the vector.
    always_comb begin
        sel_hit  = '0;
        sel_free = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                sel_free   = slot_free[k];
            end
        end
    end

    assign sel_in_range = |sel_hit;

    // Ready never depends on in_data. Out-of-range words are always taken so
    // they can be dropped; a broadcast waits until every slot can accept.
    always_comb begin
        if (rst)
            in_ready = 1'b0;
        else if (bcast_on)
            in_ready = &slot_free;
        else if (sel_in_range)
            in_ready = sel_free;
        else
            in_ready = 1'b1;
    end

    assign accept = in_valid && in_ready;
    assign load   = accept ? (bcast_on ? {N{1'b1}} : sel_hit) : '0;
    assign drop   = accept && !bcast_on && !sel_in_range;

    // Per-channel holding registers. A load wins over a drain, which is what
    // gives back-to-back throughput on one channel. Data is left untouched
    // after a drain so consumers see a stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    out_valid[k]                 <= 1'b1;
                    out_data[k*WIDTH +: WIDTH]   <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k]                 <= 1'b0;
                end
            end
        end
    end

    // Saturating count of discarded out-of-range words.
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1xn
//
// Directed bench for stream_demux_1xn. The main instance uses the default
// 8-bit, 4-channel configuration; a second 3-channel instance exercises the
// out-of-range drop path. Broadcast steps are compiled in with DEMUX_BCAST_EN.
// ---------------------------------------------------------------------------
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;
`ifdef DEMUX_BCAST_EN
    logic        bcast;
`endif

    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic [7:0]  drop_cnt3;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int badReady;
    int badValid;

    stream_demux_1xn #(.WIDTH(8), .N(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
`ifdef DEMUX_BCAST_EN
        .bcast     (bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    stream_demux_1xn #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .sel       (sel3),
`ifdef DEMUX_BCAST_EN
        .bcast     (1'b0),
`endif
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .drop_cnt  (drop_cnt3)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the main instance's inputs for the coming cycle.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic [7:0] d, input logic [3:0] rdy);
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = rdy;
    endtask

    // One compared value; the assertion's pass action steps the pass count.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'hEE, 4'b0000);
        in_valid3  = 1'b0;
        sel3       = 2'd0;
        out_ready3 = 3'b111;
`ifdef DEMUX_BCAST_EN
        bcast      = 1'b0;
`endif

        // Reset held for two cycles with a word being offered.
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("rst_out_valid_c1", {28'd0, out_valid}, 32'd0);
        checkOutput("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        tick();
        checkOutput("rst_out_valid_c2", {28'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready_c2", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        tick();
        checkOutput("post_rst_nothing", {28'd0, out_valid}, 32'd0);
        checkOutput("rst_drop_cnt3", {24'd0, drop_cnt3}, 32'd0);

        // Routing sweep: one word per channel on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k), 8'hA0 + 8'(k), 4'b1111);
            #1;
            checkOutput($sformatf("sweep_in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
            tick();
            checkOutput($sformatf("sweep_valid_%0d", k), {28'd0, out_valid}, 32'd1 << k);
            checkOutput($sformatf("sweep_data_%0d", k), {24'd0, out_data[k*8 +: 8]},
                        32'hA0 + 32'(k));
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        checkOutput("sweep_idle_valid", {28'd0, out_valid}, 32'd0);

        // Back-pressure on channel 2 while channel 1 keeps flowing.
        applyStimulus(1'b1, 2'd2, 8'h55, 4'b1011);
        #1;
        checkOutput("bp_first_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_first_valid", {28'd0, out_valid}, 32'h4);
        checkOutput("bp_first_data", {24'd0, out_data[23:16]}, 32'h55);
        applyStimulus(1'b1, 2'd2, 8'h66, 4'b1011);
        #1;
        checkOutput("bp_second_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bp_hold_valid", {28'd0, out_valid}, 32'h4);
        checkOutput("bp_hold_data", {24'd0, out_data[23:16]}, 32'h55);
        applyStimulus(1'b1, 2'd1, 8'h77, 4'b1011);
        #1;
        checkOutput("bp_other_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_other_valid", {28'd0, out_valid}, 32'h6);
        checkOutput("bp_other_data", {24'd0, out_data[15:8]}, 32'h77);
        checkOutput("bp_stalled_data", {24'd0, out_data[23:16]}, 32'h55);
        applyStimulus(1'b1, 2'd2, 8'h66, 4'b1111);
        #1;
        checkOutput("bp_drain_accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_reload_valid", {28'd0, out_valid}, 32'h4);
        checkOutput("bp_reload_data", {24'd0, out_data[23:16]}, 32'h66);
        checkOutput("bp_drained_data_held", {24'd0, out_data[15:8]}, 32'h77);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        checkOutput("bp_empty_valid", {28'd0, out_valid}, 32'd0);
        checkOutput("bp_data_after_drain", {24'd0, out_data[23:16]}, 32'h66);
        checkOutput("main_drop_cnt_zero", {24'd0, drop_cnt}, 32'd0);

        // Out-of-range select on the 3-channel instance: 300 drops.
        badReady  = 0;
        badValid  = 0;
        in_valid3 = 1'b1;
        sel3      = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            #1;
            if (in_ready3 !== 1'b1) badReady++;
            tick();
            if (out_valid3 !== 3'b000) badValid++;
            if (i == 9)
                checkOutput("oor_drop_cnt_10", {24'd0, drop_cnt3}, 32'd10);
            if (i == 254)
                checkOutput("oor_drop_cnt_255", {24'd0, drop_cnt3}, 32'd255);
        end
        in_valid3 = 1'b0;
        checkOutput("oor_ready_always", 32'(badReady), 32'd0);
        checkOutput("oor_no_valid", 32'(badValid), 32'd0);
        checkOutput("oor_drop_saturated", {24'd0, drop_cnt3}, 32'd255);

        // Mid-stream reset with channel 0 full and stalled.
        applyStimulus(1'b1, 2'd0, 8'h99, 4'b0000);
        tick();
        checkOutput("mid_loaded_valid", {28'd0, out_valid}, 32'h1);
        checkOutput("mid_loaded_data", {24'd0, out_data[7:0]}, 32'h99);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b0000);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("mid_rst_valid", {28'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_data", out_data, 32'd0);
        checkOutput("mid_rst_drop_cnt3", {24'd0, drop_cnt3}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
        checkOutput("mid_old_word_gone", {28'd0, out_valid}, 32'd0);

`ifdef DEMUX_BCAST_EN
        // Broadcast: load every slot, drain all but channel 0, then a second
        // broadcast waits for channel 0 to drain.
        bcast = 1'b1;
        applyStimulus(1'b1, 2'd2, 8'h3C, 4'b1110);
        #1;
        checkOutput("bc_first_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bc_first_valid", {28'd0, out_valid}, 32'hF);
        checkOutput("bc_first_data", out_data, 32'h3C3C3C3C);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1110);
        tick();
        checkOutput("bc_partial_drain", {28'd0, out_valid}, 32'h1);
        applyStimulus(1'b1, 2'd1, 8'hC3, 4'b0000);
        #1;
        checkOutput("bc_second_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bc_hold_valid", {28'd0, out_valid}, 32'h1);
        checkOutput("bc_hold_data", {24'd0, out_data[7:0]}, 32'h3C);
        applyStimulus(1'b1, 2'd1, 8'hC3, 4'b0001);
        #1;
        checkOutput("bc_second_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bc_second_valid", {28'd0, out_valid}, 32'hF);
        checkOutput("bc_second_data", out_data, 32'hC3C3C3C3);
        checkOutput("bc_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        bcast = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        tick();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
